// File: rtl/fetch_stage.sv
// IF stage with a DEPTH-slot fetch ring and the IF/ID pipeline register.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_stage #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            IFID_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned DW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pcf;
  logic [AW-1:0]   head, tail, fptr;
  logic [CW-1:0]   used, pend;
  logic [DW-1:0]   drop_cnt;

  logic [XLEN-1:0] slot_pc    [DEPTH];
  logic [31:0]     slot_instr [DEPTH];

  logic        fire, fill, rsp_drop, head_filled, head_avail, pop;
  logic [31:0] head_instr;

  // A response aimed at an empty head is forwarded straight into IF/ID.
  always_comb begin
    imem_req_valid = rst && !StallF && !PCSrcE && (used < CW'(DEPTH));
    imem_req_addr  = pcf;
    fire           = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    fill           = imem_rsp_valid && (drop_cnt == '0);
    head_filled    = (used != pend);
    head_avail     = head_filled || fill;
    head_instr     = head_filled ? slot_instr[head] : imem_rsp_data;
    pop            = !PCSrcE && !StallD && head_avail;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf      <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      used     <= '0;
      pend     <= '0;
      drop_cnt <= '0;
    end else if (PCSrcE) begin
      // Requests still in flight become stale; their responses are counted off.
      pcf      <= PCTargetE;
      head     <= tail;
      fptr     <= tail;
      used     <= '0;
      pend     <= '0;
      drop_cnt <= drop_cnt + DW'(pend) - DW'(imem_rsp_valid);
    end else begin
      if (fire) begin
        pcf  <= pcf + XLEN'(4);
        tail <= tail + AW'(1);
      end
      if (pop)      head     <= head + AW'(1);
      if (fill)     fptr     <= fptr + AW'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
      used <= used + CW'(fire) - CW'(pop);
      pend <= pend + CW'(fire) - CW'(fill);
    end
  end

  // NOTE: slot storage has no reset; the used/pend counters alone say which entries are live.
  always_ff @(posedge clk) begin
    if (fire) slot_pc[tail]    <= pcf;
    if (fill) slot_instr[fptr] <= imem_rsp_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IFID_valid <= 1'b0;
      InstrD     <= NOP;
      PCD        <= '0;
      PCPlus4D   <= '0;
    end else if (PCSrcE || FlushD) begin
      IFID_valid <= 1'b0;
    end else if (!StallD) begin
      if (head_avail) begin
        InstrD     <= head_instr;
        PCD        <= slot_pc[head];
        PCPlus4D   <= slot_pc[head] + XLEN'(4);
        IFID_valid <= 1'b1;
      end else begin
        IFID_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(fire);
      perf_dropped <= perf_dropped + 32'(imem_rsp_valid && (drop_cnt != '0 || PCSrcE));
    end
  end
`endif

  rsp_has_slot: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (drop_cnt != '0 || pend != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of the fetch stream.
// Build with FETCH_PERF_EN defined to also check the perf counters.
module tb_fetch_stage;

  localparam int          DEPTH  = 2;
  localparam int          NCYC   = 3000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        IFID_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .IFID_valid(IFID_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic        have;
    logic [31:0] instr;
  } slot_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  // Fetch stream model: slots in program order, stale-response count, IF/ID contents.
  slot_t       ring[$];
  mreq_t       mq[$];
  logic [31:0] m_pcf, m_instr, m_pc, m_pc4;
  logic        m_valid, exp_req;
  int          m_drop, m_fetched, m_dropped, last_due, cyc, lat;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[31:16]};
  endfunction

  task automatic model_step();
    logic  fire, head_ok, found;
    slot_t s;
    int    d;
    fire = exp_req && imem_req_ready;
    if (imem_rsp_valid) begin
      if (m_drop > 0 || PCSrcE) m_dropped++;
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        found = 1'b0;
        foreach (ring[i]) begin
          if (!found && !ring[i].have) begin
            ring[i].have  = 1'b1;
            ring[i].instr = imem_rsp_data;
            found         = 1'b1;
          end
        end
        check("rsp_slot", 32'(found), 32'd1);
      end
    end
    head_ok = (ring.size() > 0) && ring[0].have;
    if (PCSrcE || FlushD) begin
      m_valid = 1'b0;
      if (!StallD && head_ok) s = ring.pop_front();
    end else if (!StallD) begin
      if (head_ok) begin
        s       = ring.pop_front();
        m_valid = 1'b1;
        m_instr = s.instr;
        m_pc    = s.pc;
        m_pc4   = s.pc + 32'd4;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (fire) begin
      ring.push_back('{pc: m_pcf, have: 1'b0, instr: 32'h0});
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: m_pcf, due: d});
      m_pcf = m_pcf + 32'd4;
      m_fetched++;
    end
    if (PCSrcE) begin
      foreach (ring[i]) if (!ring[i].have) m_drop++;
      ring.delete();
      m_pcf = PCTargetE;
    end
  endtask

  task automatic drive_inputs();
    logic quiet;
    quiet          = (cyc < 40);
    StallF         = quiet ? 1'b0 : ($urandom_range(7) == 0);
    StallD         = quiet ? 1'b0 : ($urandom_range(5) == 0);
    FlushD         = quiet ? 1'b0 : ($urandom_range(9) == 0);
    PCSrcE         = quiet ? 1'b0 : ($urandom_range(11) == 0);
    imem_req_ready = quiet ? 1'b1 : ($urandom_range(3) != 0);
    case ($urandom_range(7))
      0:       PCTargetE = 32'hFFFF_FFF8;
      1:       PCTargetE = 32'h0000_0100;
      default: PCTargetE = $urandom & 32'hFFFF_FFFC;
    endcase
    if (cyc >= 100 && cyc < 105) begin
      imem_req_ready = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    end
    if (cyc >= 150 && cyc < 153) begin
      StallD = 1'b1; StallF = 1'b0; imem_req_ready = 1'b1; FlushD = 1'b0; PCSrcE = 1'b0;
    end
    if (cyc == 200) begin
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    end
    lat = quiet ? 1 : int'($urandom_range(3, 1));
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  initial begin
    rst = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    m_pcf = 32'h0; m_valid = 1'b0; m_instr = NOP; m_pc = 32'h0; m_pc4 = 32'h0;
    m_drop = 0; m_fetched = 0; m_dropped = 0; last_due = -1; cyc = 0; lat = 1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_ifid_valid", 32'(IFID_valid), 32'(m_valid));
    check("rst_instr", InstrD, m_instr);
    check("rst_pcd", PCD, m_pc);
    check("rst_pc4", PCPlus4D, m_pc4);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_dropped", perf_dropped, 32'd0);
`endif

    @(negedge clk);
    rst = 1'b1;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      drive_inputs();
      #1;
      exp_req = !StallF && !PCSrcE && (ring.size() < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, m_pcf);
      check("ifid_valid", 32'(IFID_valid), 32'(m_valid));
      if (m_valid) begin
        check("instr_d", InstrD, m_instr);
        check("pc_d", PCD, m_pc);
        check("pc_plus4_d", PCPlus4D, m_pc4);
      end
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, 32'(m_fetched));
      check("perf_dropped", perf_dropped, 32'(m_dropped));
`endif
      model_step();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
